// File: rtl/enc_param_ctrl.sv
// enc_param_ctrl: rotary encoder + pushbutton front end editing a parameter bank
module enc_param_ctrl #(
    parameter int NREG       = 4,
    parameter int WIDTH      = 8,
    parameter int MAX_VAL    = 255,
    parameter int DEB_CYCLES = 4,
    localparam int IW        = $clog2(NREG),
    localparam int CW        = $clog2(DEB_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enc_a,
    input  logic                  enc_b,
    input  logic                  btn_n,
    output logic [IW-1:0]         idx,
    output logic [WIDTH-1:0]      val,
    output logic                  edit,
    output logic                  upd,
    output logic [NREG*WIDTH-1:0] params
);
    typedef enum logic {BROWSE, EDIT} state_t;
    state_t                        state;
    logic [1:0]                    a_sync, b_sync, btn_sync;
    logic [1:0]                    prev;
    logic                          prev_v, step_up, step_dn;
    logic                          deb, press;
    logic [CW-1:0]                 cnt;
    logic [NREG-1:0][WIDTH-1:0]    bank;
    logic [1:0]                    q;
    logic [3:0]                    pq;
    logic                          fwd, rev;
    logic [WIDTH-1:0]              cur;
    assign q      = {b_sync[1], a_sync[1]};
    assign pq     = {prev, q};
    assign fwd    = pq == 4'b0001 || pq == 4'b0111 || pq == 4'b1110 || pq == 4'b1000;
    assign rev    = pq == 4'b0010 || pq == 4'b1011 || pq == 4'b1101 || pq == 4'b0100;
    assign cur    = bank[idx];
    assign val    = cur;
    assign params = bank;
    assign edit   = state == EDIT;
    // two-flop synchronisers; the button idles released (high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync   <= 2'b00;
            b_sync   <= 2'b00;
            btn_sync <= 2'b11;
        end else begin
            a_sync   <= {a_sync[0], enc_a};
            b_sync   <= {b_sync[0], enc_b};
            btn_sync <= {btn_sync[0], btn_n};
        end
    end
    // quadrature decode; the first sample after reset only primes prev
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 2'b00;
            prev_v  <= 1'b0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
        end else begin
            prev    <= q;
            prev_v  <= 1'b1;
            step_up <= prev_v && fwd;
            step_dn <= prev_v && rev;
        end
    end
    // debounce: level flips after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                deb   <= ~deb;
                press <= deb;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    // browse/edit FSM; a press in the same cycle as a step discards the step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BROWSE;
            idx   <= '0;
            bank  <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (press) begin
                state <= state == BROWSE ? EDIT : BROWSE;
            end else if (state == BROWSE) begin
                idx <= step_up ? idx + 1'b1 : step_dn ? idx - 1'b1 : idx;
            end else if (step_up && cur < WIDTH'(MAX_VAL)) begin
                bank[idx] <= cur + 1'b1;
                upd       <= 1'b1;
            end else if (step_dn && cur != '0) begin
                bank[idx] <= cur - 1'b1;
                upd       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_enc_param_ctrl.sv
// tb_enc_param_ctrl: directed bench for enc_param_ctrl
module tb_enc_param_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        btn_n = 1'b1;
    logic [1:0]  idx;
    logic [7:0]  val;
    logic        edit;
    logic        upd;
    logic [31:0] params;
    logic [1:0]  q = 2'b00;
    int          n_vec = 0;
    int          n_err = 0;
    int          upd_cnt = 0;
    int          base;

    enc_param_ctrl dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn_n(btn_n),
        .idx(idx), .val(val), .edit(edit), .upd(upd), .params(params)
    );

    always #5 clk = ~clk;

    // count every cycle where upd is high
    always @(posedge clk) if (upd === 1'b1) upd_cnt <= upd_cnt + 1;

    function automatic logic [1:0] fw(input logic [1:0] x);
        return x == 2'b00 ? 2'b01 : x == 2'b01 ? 2'b11 : x == 2'b11 ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] rv(input logic [1:0] x);
        return x == 2'b00 ? 2'b10 : x == 2'b10 ? 2'b11 : x == 2'b11 ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mv(input logic [1:0] nq, input int n);
        q = nq;
        {enc_b, enc_a} = nq;
        cyc(n);
    endtask

    task automatic push;
        btn_n = 1'b0;
        cyc(10);
        btn_n = 1'b1;
        cyc(10);
    endtask

    initial begin
        cyc(3);
        chk("reset idx", 32'(idx), 0);
        chk("reset val", 32'(val), 0);
        chk("reset edit", 32'(edit), 0);
        chk("reset upd", 32'(upd), 0);
        chk("reset params", params, 0);
        rst = 1'b0;
        cyc(10);
        // browse forward
        mv(2'b01, 10); chk("browse fwd 1", 32'(idx), 1);
        mv(2'b11, 10); chk("browse fwd 2", 32'(idx), 2);
        mv(2'b10, 10); chk("browse fwd 3", 32'(idx), 3);
        chk("browse edit", 32'(edit), 0);
        chk("browse no upd", upd_cnt, 0);
        chk("browse params", params, 0);
        // browse reverse with wrap
        mv(2'b11, 10); chk("browse rev 2", 32'(idx), 2);
        mv(2'b01, 10); chk("browse rev 1", 32'(idx), 1);
        mv(2'b00, 10); chk("browse rev 0", 32'(idx), 0);
        mv(2'b10, 10); chk("browse wrap low", 32'(idx), 3);
        mv(2'b11, 10); chk("browse rev 2b", 32'(idx), 2);
        // enter edit, step param 2 up then down past zero
        push;
        chk("edit entered", 32'(edit), 1);
        base = upd_cnt;
        mv(fw(q), 10); chk("edit inc 1", 32'(val), 1);
        mv(fw(q), 10); chk("edit inc 2", 32'(val), 2);
        mv(fw(q), 10); chk("edit inc 3", 32'(val), 3);
        chk("edit param2", params, 32'h0003_0000);
        for (int i = 0; i < 6; i++) mv(rv(q), 10);
        chk("edit floor", 32'(val), 0);
        chk("edit upd count", upd_cnt - base, 6);
        // short press rejected, invalid double transition ignored
        btn_n = 1'b0;
        cyc(3);
        btn_n = 1'b1;
        cyc(10);
        chk("short press", 32'(edit), 1);
        mv(~q, 10);
        chk("invalid idx", 32'(idx), 2);
        chk("invalid val", 32'(val), 0);
        // back to browse, move to idx 0, edit up to saturation
        push;
        chk("browse again", 32'(edit), 0);
        mv(fw(q), 10);
        mv(fw(q), 10);
        chk("idx wrap high", 32'(idx), 0);
        push;
        chk("edit p0", 32'(edit), 1);
        base = upd_cnt;
        for (int i = 0; i < 254; i++) mv(fw(q), 6);
        chk("preload 254", 32'(val), 254);
        chk("preload upd", upd_cnt - base, 254);
        base = upd_cnt;
        mv(fw(q), 10); chk("sat 255", 32'(val), 255);
        mv(fw(q), 10); chk("sat hold", 32'(val), 255);
        chk("sat upd once", upd_cnt - base, 1);
        chk("sat params", params, 32'h0000_00ff);
        // press and reverse step land in the same cycle
        base = upd_cnt;
        btn_n = 1'b0;
        cyc(3);
        mv(rv(q), 10);
        btn_n = 1'b1;
        cyc(10);
        chk("press wins edit", 32'(edit), 0);
        chk("press wins val", 32'(val), 255);
        chk("press wins idx", 32'(idx), 0);
        chk("press wins upd", upd_cnt - base, 0);
        // reset while editing and mid-debounce
        push;
        chk("edit before rst", 32'(edit), 1);
        btn_n = 1'b0;
        cyc(2);
        {enc_b, enc_a} = 2'b11;
        #3 rst = 1'b1;
        #1;
        chk("async rst idx", 32'(idx), 0);
        chk("async rst edit", 32'(edit), 0);
        chk("async rst val", 32'(val), 0);
        chk("async rst params", params, 0);
        btn_n = 1'b1;
        base = upd_cnt;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        chk("post rst idx", 32'(idx), 0);
        chk("post rst edit", 32'(edit), 0);
        chk("post rst upd", upd_cnt - base, 0);
        chk("post rst params", params, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/enc_param_ctrl.md
Name: enc_param_ctrl

Overview:
Front-end controller that turns the raw rotary-encoder channels and pushbutton pins into edits of a small parameter bank. The parameter values drive the downstream datapath.
- Synchronises and decodes quadrature (one count per valid edge transition).
- Debounces the active-low pushbutton.
- Runs a BROWSE/EDIT state machine: the encoder either selects a parameter or changes its value.

Parameters:
NREG, 4, number of parameter registers (power of two, 2..16)
WIDTH, 8, bits per parameter
MAX_VAL, 255, upper saturation limit of a parameter value (must be < 2^WIDTH)
DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a button level change (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enc_a  in  1  encoder channel A (async pin)
enc_b  in  1  encoder channel B (async pin)
btn_n  in  1  pushbutton, 0 = pressed (async pin)
idx  out  log2(NREG)  currently selected parameter index
val  out  WIDTH  value of the selected parameter
edit  out  1  1 = EDIT mode, 0 = BROWSE mode
upd  out  1  one-cycle pulse when any parameter value changes
params  out  NREG*WIDTH  flattened bank; param k at [k*WIDTH +: WIDTH]

Behaviour:
- Reset (async assert):
  - All params = 0, idx = 0, edit = 0, upd = 0, state = BROWSE.
  - Sync flops for enc_a/enc_b = 0; sync flop for btn_n = 1; debounced button = released; debounce counter = 0.
  - Decoder "prev valid" flag = 0.
- Synchronisers: 2 flops per input; all logic uses the synchronised values.
- Quadrature decode on q = {b_s, a_s}:
  - Forward cycle 00→01→11→10→00: one transition = +1 step. Reverse cycle = -1 step.
  - Both bits changed (00↔11, 01↔10): invalid, ignored; prev is updated to the new value.
  - No change: no step.
  - First cycle after reset with prev-valid=0: load prev, set valid, no step.
  - Step pulse is registered. Latency is 3 clk from pin edge to step (2 sync + 1 decode); state/param update in the following cycle.
- Button debounce:
  - The counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - At DEB_CYCLES the debounced level flips and the counter clears.
  - Press event = one-cycle pulse on the debounced 1→0 flip. Release generates no event.
- FSM:
  - BROWSE: +1 step → idx = idx+1 mod NREG; -1 step → idx = idx-1 mod NREG (wraps both ways). Press → EDIT.
  - EDIT: +1 step → param[idx] = min(param[idx]+1, MAX_VAL); -1 step → param[idx] = max(param[idx]-1, 0). Saturates, never wraps. Press → BROWSE.
- upd: pulses for 1 cycle only when a stored value actually changes. No pulse at saturation, and no pulse in BROWSE.
- Simultaneous press and step in the same cycle: press wins; the step is discarded.
- Outputs are registered. val = params[idx] is combinational from registered state, so it updates in the same cycle as idx/params.
- Reset mid-operation (e.g. mid-debounce or in EDIT): everything returns to reset values immediately; no pending event survives.

Test Plan:
1. Reset, pins {b,a}=00, btn_n=1. Release rst; drive 01,11,10 at 10-cycle spacing → idx 0→1→2→3, edit=0, upd never pulses, params all 0.
2. From idx=3, drive 11 → idx=2. Then 01,00,10,11 → idx 1,0,3,2 (wrap below 0 and above NREG-1).
3. Press (btn_n low 10 cycles, then high) → edit=1 exactly once. Drive forward steps 01,11,10 → param[2] 0→1→2→3 with upd pulses. Six reverse steps → value 3→0, then stays 0; only 3 upd pulses.
4. btn_n low for DEB_CYCLES-1 cycles, then high → no mode change. Drive 00→11 directly → no step, idx/val unchanged.
5. Preload param[0]=254 via forward steps, then two more forward steps → 255, then held at 255; exactly one upd for 254→255. Assert a press in the same cycle as a step → mode toggles, value unchanged.
6. Assert rst while edit=1 and button mid-debounce → all outputs 0 asynchronously. After release, no spurious step or press even if pins sit at 11.
